// File: rtl/zxbus_host_if.sv
// Bundle of the local request/response handshake and the ZX-bus pins for zxbus_host.
// Handshake: a request is taken on a clock edge where req=1 and ready=1; req seen
// while ready=0 is dropped, never queued. rsp_valid is a one-cycle pulse per accepted
// request, and rsp_data/rsp_timeout are meaningful in that cycle.
interface zxbus_host_if;
  logic       req;
  logic       req_wr;
  logic [15:0] req_addr;
  logic [7:0] req_data;
  logic       ready;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_timeout;
  logic [7:0] zxa;
  logic       zxa14;
  logic       zxa15;
  logic       zxiorq_n;
  logic       zxmreq_n;
  logic       zxrd_n;
  logic       zxwr_n;
  logic [7:0] zxid_o;
  logic       zxid_oe;
  logic [7:0] zxid_i;
  logic       zxgenwait_n;

  // Host side: takes requests, drives the bus.
  modport master (
    input  req, req_wr, req_addr, req_data, zxid_i, zxgenwait_n,
    output ready, rsp_valid, rsp_data, rsp_timeout,
    output zxa, zxa14, zxa15, zxiorq_n, zxmreq_n, zxrd_n, zxwr_n, zxid_o, zxid_oe
  );

  // Controller plus bus-slave side: issues requests, answers on the bus.
  modport slave (
    output req, req_wr, req_addr, req_data, zxid_i, zxgenwait_n,
    input  ready, rsp_valid, rsp_data, rsp_timeout,
    input  zxa, zxa14, zxa15, zxiorq_n, zxmreq_n, zxrd_n, zxwr_n, zxid_o, zxid_oe
  );
endinterface

// File: rtl/zxbus_host.sv
// ZX-bus I/O cycle initiator: turns single-byte read/write requests into timed
// IORQ cycles (setup, strobe with wait-state extension, hold) and reports
// completion with a one-cycle rsp_valid pulse. All outputs are registered.
module zxbus_host #(
  parameter int T_SETUP  = 2,
  parameter int T_STROBE = 4,
  parameter int T_HOLD   = 2,
  parameter int WAIT_MAX = 255
) (
  input  logic         clk,
  input  logic         rst,
  zxbus_host_if.master bus,
  output logic [2:0]   dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_WAIT   = 3'd3,
    S_HOLD   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [7:0] SETUP_LD  = 8'(T_SETUP - 1);
  localparam logic [7:0] STROBE_LD = 8'(T_STROBE - 1);
  localparam logic [7:0] HOLD_LD   = 8'(T_HOLD - 1);
  localparam logic [7:0] WAIT_LD   = 8'(WAIT_MAX - 1);

  state_t     state_q;
  logic [7:0] cnt_q;
  logic       wr_q;
  logic       timeout_q;
  logic       ready_q;
  logic       rsp_valid_q;
  logic [7:0] rsp_data_q;
  logic       rsp_timeout_q;
  logic [7:0] zxa_q;
  logic       zxa14_q;
  logic       zxa15_q;
  logic       iorq_n_q;
  logic       rd_n_q;
  logic       wr_n_q;
  logic [7:0] zxid_o_q;
  logic       zxid_oe_q;
  logic       wait_meta_q;
  logic       wait_sync_q;

  // Two-flop synchroniser for the slave's asynchronous wait request (idle high).
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_meta_q <= 1'b1;
      wait_sync_q <= 1'b1;
    end else begin
      wait_meta_q <= bus.zxgenwait_n;
      wait_sync_q <= wait_meta_q;
    end
  end

  // Bus-cycle sequencer; one shared down-counter times every phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= 8'd0;
      wr_q          <= 1'b0;
      timeout_q     <= 1'b0;
      ready_q       <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 8'hFF;
      rsp_timeout_q <= 1'b0;
      zxa_q         <= 8'd0;
      zxa14_q       <= 1'b0;
      zxa15_q       <= 1'b0;
      iorq_n_q      <= 1'b1;
      rd_n_q        <= 1'b1;
      wr_n_q        <= 1'b1;
      zxid_o_q      <= 8'd0;
      zxid_oe_q     <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req) begin
            wr_q      <= bus.req_wr;
            zxa_q     <= bus.req_addr[7:0];
            zxa14_q   <= bus.req_addr[14];
            zxa15_q   <= bus.req_addr[15];
            if (bus.req_wr) begin
              zxid_o_q  <= bus.req_data;
              zxid_oe_q <= 1'b1;
            end
            timeout_q <= 1'b0;
            ready_q   <= 1'b0;
            cnt_q     <= SETUP_LD;
            state_q   <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt_q == 8'd0) begin
            iorq_n_q <= 1'b0;
            if (wr_q) wr_n_q <= 1'b0;
            else      rd_n_q <= 1'b0;
            cnt_q   <= STROBE_LD;
            state_q <= S_STROBE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_STROBE: begin
          if (cnt_q == 8'd0) begin
            if (!wait_sync_q) begin
              cnt_q   <= WAIT_LD;
              state_q <= S_WAIT;
            end else begin
              rsp_data_q <= wr_q ? 8'hFF : bus.zxid_i;
              iorq_n_q   <= 1'b1;
              rd_n_q     <= 1'b1;
              wr_n_q     <= 1'b1;
              cnt_q      <= HOLD_LD;
              state_q    <= S_HOLD;
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_WAIT: begin
          if (wait_sync_q) begin
            rsp_data_q <= wr_q ? 8'hFF : bus.zxid_i;
            iorq_n_q   <= 1'b1;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            cnt_q      <= HOLD_LD;
            state_q    <= S_HOLD;
          end else if (cnt_q == 8'd0) begin
            // Slave never released the bus: abandon the cycle with a dummy byte.
            timeout_q  <= 1'b1;
            rsp_data_q <= 8'hFF;
            iorq_n_q   <= 1'b1;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            cnt_q      <= HOLD_LD;
            state_q    <= S_HOLD;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_HOLD: begin
          if (cnt_q == 8'd0) begin
            zxid_oe_q <= 1'b0;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_DONE: begin
          rsp_valid_q   <= 1'b1;
          rsp_timeout_q <= timeout_q;
          ready_q       <= 1'b1;
          state_q       <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ready       = ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.zxa         = zxa_q;
  assign bus.zxa14       = zxa14_q;
  assign bus.zxa15       = zxa15_q;
  assign bus.zxiorq_n    = iorq_n_q;
  assign bus.zxmreq_n    = 1'b1;
  assign bus.zxrd_n      = rd_n_q;
  assign bus.zxwr_n      = wr_n_q;
  assign bus.zxid_o      = zxid_o_q;
  assign bus.zxid_oe     = zxid_oe_q;
  assign dbg_state_o     = state_q;

endmodule
